ext_pwr_gate_ctrl: RTL



---
 rtl/ext_pwr_gate_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ext_pwr_gate_ctrl.sv
// Power-gate sequencer for one external domain: orders clock gate, isolation,
// domain reset and power switch, and handshakes with the switch-cell ack.
module ext_pwr_gate_ctrl #(
  parameter int SEQ_DELAY       = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int ACK_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_off_req_i,
  input  logic err_clr_i,
  input  logic switch_ack_ni,
  output logic switch_no,
  output logic iso_no,
  output logic rst_no,
  output logic clkgate_en_no,
  output logic busy_o,
  output logic powered_o,
  output logic off_o,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(SEQ_DELAY - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_ON, S_OFF_CLK, S_OFF_ISO, S_OFF_RST, S_OFF_SW, S_OFF,
    S_ON_SW, S_ON_SETTLE, S_ON_ISO, S_ON_RST, S_ON_CLK
  } state_t;

  state_t                     state, next_state;
  logic [CNT_W-1:0]           cnt, load_val;
  logic [ACK_SYNC_STAGES-1:0] ack_sync;
  logic                       ack_s, cnt_zero, load, to_evt;
  logic                       sw_d, iso_d, rst_d, clk_d, busy_d, pow_d, off_d;

  assign ack_s    = ack_sync[ACK_SYNC_STAGES-1];
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync <= '0;
      state    <= S_ON;
      cnt      <= '0;
    end else begin
      ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], switch_ack_ni};
      state    <= next_state;
      if (load)          cnt <= load_val;
      else if (!cnt_zero) cnt <= cnt - 1'b1;
    end
  end

  // Timeout fires once, on the 1->0 step of the wait counter; set beats clear.
  always_comb begin
    next_state = state;
    to_evt     = 1'b0;
    case (state)
      S_ON:        if (pwr_off_req_i) next_state = S_OFF_CLK;
      S_OFF_CLK:   if (cnt_zero) next_state = S_OFF_ISO;
      S_OFF_ISO:   if (cnt_zero) next_state = S_OFF_RST;
      S_OFF_RST:   if (cnt_zero) next_state = S_OFF_SW;
      S_OFF_SW: begin
        if (ack_s)                   next_state = S_OFF;
        else if (cnt == CNT_W'(1))   to_evt = 1'b1;
      end
      S_OFF:       if (!pwr_off_req_i) next_state = S_ON_SW;
      S_ON_SW: begin
        if (!ack_s)                  next_state = S_ON_SETTLE;
        else if (cnt == CNT_W'(1))   to_evt = 1'b1;
      end
      S_ON_SETTLE: if (cnt_zero) next_state = S_ON_ISO;
      S_ON_ISO:    if (cnt_zero) next_state = S_ON_RST;
      S_ON_RST:    if (cnt_zero) next_state = S_ON_CLK;
      S_ON_CLK:    if (cnt_zero) next_state = S_ON;
      default:     next_state = S_ON;
    endcase
    load     = (next_state != state);
    load_val = (next_state == S_OFF_SW || next_state == S_ON_SW) ? WAIT_LOAD : STEP_LOAD;
  end

  always_comb begin
    sw_d   = 1'b0;
    iso_d  = 1'b1;
    rst_d  = 1'b1;
    clk_d  = 1'b1;
    busy_d = 1'b1;
    pow_d  = 1'b0;
    off_d  = 1'b0;
    case (state)
      S_ON:      begin busy_d = 1'b0; pow_d = 1'b1; end
      S_OFF_CLK: clk_d = 1'b0;
      S_OFF_ISO: begin clk_d = 1'b0; iso_d = 1'b0; end
      S_OFF_RST: begin clk_d = 1'b0; iso_d = 1'b0; rst_d = 1'b0; end
      S_OFF_SW:  begin clk_d = 1'b0; iso_d = 1'b0; rst_d = 1'b0; sw_d = 1'b1; end
      S_OFF: begin
        clk_d = 1'b0; iso_d = 1'b0; rst_d = 1'b0; sw_d = 1'b1;
        busy_d = 1'b0; off_d = 1'b1;
      end
      S_ON_SW, S_ON_SETTLE: begin clk_d = 1'b0; iso_d = 1'b0; rst_d = 1'b0; end
      S_ON_ISO:  begin clk_d = 1'b0; rst_d = 1'b0; end
      S_ON_RST:  clk_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      switch_no     <= 1'b0;
      iso_no        <= 1'b1;
      rst_no        <= 1'b1;
      clkgate_en_no <= 1'b1;
      busy_o        <= 1'b0;
      powered_o     <= 1'b1;
      off_o         <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      switch_no     <= sw_d;
      iso_no        <= iso_d;
      rst_no        <= rst_d;
      clkgate_en_no <= clk_d;
      busy_o        <= busy_d;
      powered_o     <= pow_d;
      off_o         <= off_d;
      if (to_evt)         timeout_o <= 1'b1;
      else if (err_clr_i) timeout_o <= 1'b0;
    end
  end

endmodule
